fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus IF/ID pipeline register with stall and branch flush.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic [31:0] inst_addr,
    input  logic [31:0] instruction,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;

    logic [31:0] if_pc_q;
    logic [31:0] if_pc_next;
    logic [31:0] if_inst_q;
    logic [31:0] if_inst_next;
    logic        if_valid_q;
    logic        if_valid_next;

    // Branch outranks freeze; advance only when neither redirect nor stall is active.
    logic        do_flush;
    logic        do_advance;
    logic        do_stall;

    assign do_flush   = branch_taken;
    assign do_advance = !branch_taken && !freeze;
    assign do_stall   = !branch_taken && freeze;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_next       = pc_q;
        if_pc_next    = if_pc_q;
        if_inst_next  = if_inst_q;
        if_valid_next = if_valid_q;
        if (do_flush) begin
            pc_next       = {branch_addr[31:2], 2'b00};
            if_pc_next    = 32'd0;
            if_inst_next  = 32'd0;
            if_valid_next = 1'b0;
        end else if (do_advance) begin
            pc_next       = pc_plus4;
            if_pc_next    = pc_plus4;
            if_inst_next  = instruction;
            if_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= 32'd0;
            if_pc_q    <= 32'd0;
            if_inst_q  <= 32'd0;
            if_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_next;
            if_pc_q    <= if_pc_next;
            if_inst_q  <= if_inst_next;
            if_valid_q <= if_valid_next;
        end
    end

    // inst_addr comes straight from the PC flop so memory sees no input-to-address path.
    assign inst_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;
    assign if_valid  = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            if (do_advance) fetch_count_q <= fetch_count_q + 32'd1;
            if (do_stall)   stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_stall;
    assign unused_stall = do_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized freeze/branch traffic
// compared against a reference model through an expected-value queue.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] inst_addr;
    logic [31:0] instruction;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .inst_addr    (inst_addr),
        .instruction  (instruction),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid)
`ifdef FETCH_PERF_CNT_EN
       ,.fetch_count  (fetch_count),
        .stall_count  (stall_count)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory: deterministic word per address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    assign instruction = mem_word(inst_addr);

    // expected entry: {pc, if_pc, if_inst, if_valid, fetch_count, stall_count}
    localparam int W = 161;
    logic [W-1:0] exp_q[$];

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_inst;
    logic        m_if_valid;
    logic [31:0] m_fetches;
    logic [31:0] m_stalls;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = 32'd0;
        m_if_pc    = 32'd0;
        m_if_inst  = 32'd0;
        m_if_valid = 1'b0;
        m_fetches  = 32'd0;
        m_stalls   = 32'd0;
    endtask

    // one clock of stimulus; expected post-edge state goes to the queue
    task automatic step(input logic fz, input logic bt, input logic [31:0] ba);
        freeze       = fz;
        branch_taken = bt;
        branch_addr  = ba;
        if (bt) begin
            m_pc       = ba & 32'hFFFF_FFFC;
            m_if_pc    = 32'd0;
            m_if_inst  = 32'd0;
            m_if_valid = 1'b0;
        end else if (!fz) begin
            m_if_inst  = mem_word(m_pc);
            m_if_pc    = m_pc + 32'd4;
            m_pc       = m_pc + 32'd4;
            m_if_valid = 1'b1;
            m_fetches  = m_fetches + 32'd1;
        end else begin
            m_stalls = m_stalls + 32'd1;
        end
        exp_q.push_back({m_pc, m_if_pc, m_if_inst, m_if_valid, m_fetches, m_stalls});
        @(posedge clk);
        #2;
    endtask

    // monitor: compares DUT outputs #1 after each active edge
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("inst_addr", inst_addr, e[160:129]);
            check("if_pc", if_pc, e[128:97]);
            check("if_inst", if_inst, e[96:65]);
            check("if_valid", {31'd0, if_valid}, {31'd0, e[64]});
`ifdef FETCH_PERF_CNT_EN
            check("fetch_count", fetch_count, e[63:32]);
            check("stall_count", stall_count, e[31:0]);
`endif
        end
    end

    // asserts reset mid-cycle, checks the immediate effect, holds across edges, releases
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_inst_addr", inst_addr, 32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_inst", if_inst, 32'd0);
        check("rst_if_pc", if_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_stall_count", stall_count, 32'd0);
`endif
        exp_q.delete();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst_hold_inst_addr", inst_addr, 32'd0);
        rst_n        = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
    endtask

    initial begin
        rst_n        = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        model_reset();
        @(posedge clk);
        #2;
        do_reset();

        // straight-line fetch
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("line_inst_addr", inst_addr, 32'd12);
        check("line_if_pc", if_pc, 32'd12);
        check("line_if_inst", if_inst, mem_word(32'd8));
        check("line_if_valid", {31'd0, if_valid}, 32'd1);

        // freeze at inst_addr=8
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        check("frz_inst_addr", inst_addr, 32'd8);
        check("frz_if_pc", if_pc, 32'd8);
        check("frz_if_inst", if_inst, mem_word(32'd4));
        step(1'b0, 1'b0, 32'd0);
        check("frz_rel_inst_addr", inst_addr, 32'd12);
        check("frz_rel_if_pc", if_pc, 32'd12);

        // branch then capture at target
        step(1'b0, 1'b1, 32'h70);
        check("br_inst_addr", inst_addr, 32'h70);
        check("br_if_valid", {31'd0, if_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check("br_if_inst", if_inst, mem_word(32'h70));
        check("br_if_pc", if_pc, 32'h74);
        check("br_if_valid2", {31'd0, if_valid}, 32'd1);

        // branch with freeze, unaligned target
        step(1'b1, 1'b1, 32'h5E);
        check("brfrz_inst_addr", inst_addr, 32'h5C);
        check("brfrz_if_valid", {31'd0, if_valid}, 32'd0);

        // PC wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        check("wrap_inst_addr", inst_addr, 32'd0);
        check("wrap_if_pc", if_pc, 32'd0);
        check("wrap_if_inst", if_inst, mem_word(32'hFFFF_FFFC));

        // reset during freeze and branch
        step(1'b1, 1'b0, 32'd0);
        freeze = 1'b1;
        do_reset();
        step(1'b0, 1'b0, 32'd0);
        check("post_rst_if_inst", if_inst, mem_word(32'd0));
        branch_taken = 1'b1;
        branch_addr  = 32'h400;
        do_reset();

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            logic fz;
            logic bt;
            logic [31:0] ba;
            fz = ($urandom_range(0, 3) == 0);
            bt = ($urandom_range(0, 7) == 0);
            ba = $urandom;
            if ($urandom_range(0, 199) == 0) do_reset();
            step(fz, bt, ba);
        end

        @(posedge clk);
        #2;
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
